// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC transmit arbiter and its round-robin picker.
// No logic and no latency; pure declarations.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } cdc_arb_state_e;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant and wraps at N.
// Zero latency; it never stalls and simply reports any=0 when nothing requests.
module rr_arbiter
    import cdc_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 1; i <= N; i++) begin
            // One extra bit keeps last_grant+i from overflowing before the wrap.
            sum = {1'b0, last_grant} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = idx;
            end
        end
    end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Shares one handshake synchronizer among NUM_REQ requesters: round-robin pick, one-cycle launch, busy tracking.
// Request-to-launch latency is 1 cycle; the block waits while sync_busy_i is high and times out if busy never rises.
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int BUSY_TIMEOUT = 15,
    localparam int ID_WIDTH     = id_width(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]             req_ack_o,
    input  logic                           sync_busy_i,
    output logic                           sync_valid_o,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] sync_data_o,
    output logic                           timeout_o
);

    localparam int                   CNT_WIDTH = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(BUSY_TIMEOUT - 1);

    cdc_arb_state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]            last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic                           sync_valid_q, sync_valid_d;
    logic [ID_WIDTH+DATA_WIDTH-1:0] sync_data_q, sync_data_d;
    logic [NUM_REQ-1:0]             req_ack_q, req_ack_d;
    logic                           timeout_q, timeout_d;

    logic [NUM_REQ-1:0]    gnt_onehot;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] win_payload;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    always_comb begin
        win_payload = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_onehot[k]) begin
                win_payload = win_payload | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        sync_valid_d = 1'b0;
        sync_data_d  = sync_data_q;
        req_ack_d    = '0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any && !sync_busy_i) begin
                    sync_data_d  = {gnt_id, win_payload};
                    last_grant_d = gnt_id;
                    sync_valid_d = 1'b1;
                    req_ack_d    = gnt_onehot;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sync_busy_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Registered pulse lands BUSY_TIMEOUT+1 cycles after the launch cycle.
                    if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!sync_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q        <= '0;
            sync_valid_q <= 1'b0;
            sync_data_q  <= '0;
            req_ack_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sync_valid_q <= sync_valid_d;
            sync_data_q  <= sync_data_d;
            req_ack_q    <= req_ack_d;
            timeout_q    <= timeout_d;
        end
    end

    assign sync_valid_o = sync_valid_q;
    assign sync_data_o  = sync_data_q;
    assign req_ack_o    = req_ack_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Randomized bench: a transaction-level model predicts each cycle's outputs into a scoreboard queue,
// and a negedge monitor pops and compares them against the DUT.
module tb_cdc_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int BT   = 15;
    localparam int IW   = 2;
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ack;
    logic              sync_busy;
    logic              sync_valid;
    logic [IW+DW-1:0]  sync_data;
    logic              timeout;

    cdc_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ack_o    (req_ack),
        .sync_busy_i  (sync_busy),
        .sync_valid_o (sync_valid),
        .sync_data_o  (sync_data),
        .timeout_o    (timeout)
    );

    typedef struct {
        int              cyc;
        logic            vld;
        logic [N-1:0]    ack;
        logic            to;
        logic [IW+DW-1:0] dat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc   = -1;
    int   n_vec = 0;
    int   n_err = 0;

    // Requester agents
    bit          pend[N];
    logic [DW-1:0] pdat[N];
    int          ack_k;

    // Reference model: whether a word is in flight, when it launched, whether busy was seen
    int          m_last;
    int          m_win;
    int          m_launch;
    bit          m_fly;
    bit          m_seen;
    logic [IW+DW-1:0] m_dat;

    int          busy_start;
    int          busy_end;
    int          n_launch;
    int          n_tmo;

    task automatic model_step();
        exp_t e;
        e.cyc = cyc + 1;
        e.vld = 1'b0;
        e.ack = '0;
        e.to  = 1'b0;
        if (reset) begin
            m_last = N - 1;
            m_fly  = 1'b0;
            m_dat  = '0;
        end else if (m_fly) begin
            if (cyc != m_launch) begin
                if (!m_seen) begin
                    if (sync_busy) begin
                        m_seen = 1'b1;
                    end else if (cyc - m_launch == BT) begin
                        e.to  = 1'b1;
                        m_fly = 1'b0;
                        n_tmo++;
                    end
                end else if (!sync_busy) begin
                    m_fly = 1'b0;
                end
            end
        end else if (req_valid != '0 && !sync_busy) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (req_valid[k]) begin
                    m_win = k;
                    break;
                end
            end
            m_last       = m_win;
            m_dat        = {IW'(m_win), pdat[m_win]};
            e.vld        = 1'b1;
            e.ack[m_win] = 1'b1;
            m_fly        = 1'b1;
            m_seen       = 1'b0;
            m_launch     = cyc + 1;
            n_launch++;
        end
        e.dat = m_dat;
        sbq.push_back(e);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        sync_busy  = 1'b0;
        busy_start = 0;
        busy_end   = -1;
        m_last     = N - 1;
        m_win      = 0;
        m_launch   = -10;
        m_fly      = 1'b0;
        m_seen     = 1'b0;
        m_dat      = '0;
        ack_k      = -1;
        n_launch   = 0;
        n_tmo      = 0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b1;
            pdat[k] = $urandom;
        end
        repeat (NCYC) begin
            @(posedge clk);
            #1;
            cyc++;
            // requesters react to the ack one cycle after it pulsed
            if (ack_k >= 0) begin
                pend[ack_k] = ($urandom_range(0, 1) == 1);
                pdat[ack_k] = $urandom;
                ack_k = -1;
            end
            if (m_fly && cyc == m_launch) begin
                ack_k = m_win;
            end
            if (cyc >= 4) begin
                for (int k = 0; k < N; k++) begin
                    if (!pend[k]) begin
                        if ($urandom_range(0, 5) == 0) begin
                            pend[k] = 1'b1;
                            pdat[k] = $urandom;
                        end
                    end else if (k != ack_k && $urandom_range(0, 149) == 0) begin
                        pend[k] = 1'b0;
                    end
                end
            end
            reset = (cyc < 4) || ($urandom_range(0, 299) == 0);
            // synchronizer: busy follows a launch; occasionally never rises or rises at the timeout edge
            if (sync_valid) begin
                int x;
                x = $urandom_range(0, 9);
                if (x == 0) begin
                    busy_start = 0;
                    busy_end   = -1;
                end else begin
                    busy_start = cyc + ((x == 1) ? BT : (x == 2) ? BT + 1 : $urandom_range(1, 3));
                    busy_end   = busy_start + $urandom_range(0, 3);
                end
            end else if (cyc > busy_end && cyc >= 4 && $urandom_range(0, 39) == 0) begin
                busy_start = cyc;
                busy_end   = cyc + $urandom_range(0, 2);
            end
            sync_busy = (cyc >= busy_start) && (cyc <= busy_end);
            for (int k = 0; k < N; k++) begin
                req_valid[k]           = pend[k];
                req_data[k*DW +: DW]   = pdat[k];
            end
            model_step();
        end
        @(negedge clk);
        #1;
        if (n_launch < 20 || n_tmo < 1) begin
            n_err++;
            $display("FAIL activity: launches=%0d timeouts=%0d, need >=20 and >=1", n_launch, n_tmo);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            n_vec++;
            if (mon_e.cyc != cyc || sync_valid !== mon_e.vld || req_ack !== mon_e.ack || timeout !== mon_e.to) begin
                n_err++;
                $display("FAIL ctrl cyc=%0d: got vld=%b ack=%b to=%b, expected vld=%b ack=%b to=%b (entry cyc %0d)",
                         cyc, sync_valid, req_ack, timeout, mon_e.vld, mon_e.ack, mon_e.to, mon_e.cyc);
            end
            n_vec++;
            if (sync_data !== mon_e.dat) begin
                n_err++;
                $display("FAIL data cyc=%0d: got %h, expected %h", cyc, sync_data, mon_e.dat);
            end
        end
    end

endmodule

// File: doc/cdc_tx_arbiter.md
# cdc_tx_arbiter

Single-clock source-domain controller that shares one handshake synchronizer among `NUM_REQ` requesters. It selects a requester round-robin and launches that requester's word into the synchronizer as a one-cycle `valid` pulse. The requester ID is tagged onto the word so the destination can demultiplex it. The block then tracks the synchronizer's `busy` flag until the channel is free again, and flags a channel that never acknowledges.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `DATA_WIDTH`, default 32: payload width per requester.
- `BUSY_TIMEOUT`, default 15: maximum cycles spent waiting for `sync_busy_i` to rise after a launch.
- `ID_WIDTH`: derived localparam, `$clog2(NUM_REQ)`.

Ports:
- `clk_i`  in  1  clock for the source domain; the only clock.
- `reset_i`  in  1  reset, synchronous and active-high.
- `req_valid_i`  in  `NUM_REQ`  per-requester request; held until acked.
- `req_data_i`  in  `NUM_REQ*DATA_WIDTH`  packed payloads; requester k occupies `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ack_o`  out  `NUM_REQ`  one-hot, one-cycle pulse; the payload has been captured.
- `sync_busy_i`  in  1  busy flag from the synchronizer.
- `sync_valid_o`  out  1  one-cycle launch pulse to the synchronizer.
- `sync_data_o`  out  `ID_WIDTH+DATA_WIDTH`  launched word, `{id, payload}`.
- `timeout_o`  out  1  one-cycle pulse; `busy` never rose after a launch.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE. The state type is an enum.
- IDLE:
  - Launch condition: at least one `req_valid_i` bit is set and `sync_busy_i`=0.
  - On launch, pick the winner round-robin, starting at `last_grant+1` and wrapping at `NUM_REQ`.
  - Register `{winner id, winner payload}` into `sync_data_o`, register the winner into `last_grant`, then go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - `sync_valid_o`=1 and `req_ack_o[winner]`=1.
  - Clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY:
  - `sync_busy_i`=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`, pulse `timeout_o` for one cycle and go to IDLE.
- WAIT_DONE:
  - `sync_busy_i`=0: go to IDLE.
  - No timeout in this state; destination latency is unbounded.
- Data hold: `sync_data_o` holds its value from LAUNCH until the next launch. Required because the synchronizer samples the data later.
- Deasserted request: if `req_valid_i[k]` drops before its ack, the request is simply not considered. The block never acks a requester whose `valid` was low in the selection cycle.
- Requester behaviour after ack: a requester may present new data and hold `req_valid_i` high in the cycle after its ack. It is then eligible at the next IDLE, behind the other pending requesters.
- Counter width: `$clog2(BUSY_TIMEOUT+1)` bits, with no wrap. The counter saturates because the timeout exits the state first.

## Timing
- Reset values: state=IDLE, `last_grant`=`NUM_REQ-1` (so requester 0 wins first), `sync_valid_o`=0, `sync_data_o`=0, `req_ack_o`=0, `timeout_o`=0, counter=0.
- Request-to-launch latency: 1 cycle. A request seen in IDLE at edge n gives `sync_valid_o`/`req_ack_o` high during cycle n+1.
- Minimum launch-to-launch spacing: 4 cycles (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE). This assumes `busy` rises one cycle after `valid` and falls one cycle later.
- Busy high in IDLE (stale or foreign): no launch. The block stays in IDLE until `sync_busy_i`=0.
- Simultaneous events: a request and `busy` falling in the same cycle in WAIT_DONE go to IDLE first. Selection happens in the following cycle; there is no bypass.
- Mid-operation reset: any state returns to IDLE on the next edge and all outputs return to their reset values. A dropped in-flight word is not re-sent, and no ack is issued for it.
- All outputs are registered.

## Structure
- Package `cdc_arb_pkg`:
  - `cdc_arb_state_e` enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
  - Helper function `id_width(n)`.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `last_grant`.
  - Outputs: `gnt_onehot`, `gnt_id`, `any`.
  - Combinational only; reusable by other schedulers.
- Top level: FSM, timeout counter, data mux/register.

## Test plan
- Reset behaviour: assert `reset_i` with all requests high. All outputs stay 0. After release, requester 0 is launched first: `sync_data_o`={0, payload0}, `req_ack_o`=0001.
- Round-robin under contention: all 4 requests held, `busy` modelled as rising 1 cycle after `valid` and falling 3 cycles later. Launch order is 0,1,2,3,0 and each ack coincides with `sync_valid_o`.
- Busy gating: `sync_busy_i`=1 in IDLE with request 2 pending. There is no launch until `busy` drops, then launch 1 cycle later with id=2.
- Timeout: `busy` never rises after a launch. `timeout_o` pulses exactly `BUSY_TIMEOUT`+1 cycles after LAUNCH, the block returns to IDLE and the next request is served.
- Reset mid-operation: reset in WAIT_DONE. State goes to IDLE and outputs clear. No spurious ack, and `last_grant` resets to 3.
- Withdrawn request: requester 1 drops `valid` while requester 3 is being served. The next grant skips 1, and `req_ack_o[1]` never pulses.
